// File: rtl/csa_eight_adder.sv
// csa_eight_adder: registered nine-operand signed carry-save adder with run-time low-column approximation.
// Define CSA_EIGHT_PIPE_EN to register the two carry-save rows ahead of the CPA (2-cycle latency).
module csa_eight_adder #(
  parameter int SIZE = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic [SIZE-1:0]   c,
  input  logic [SIZE-1:0]   d,
  input  logic [SIZE-1:0]   e,
  input  logic [SIZE-1:0]   f,
  input  logic [SIZE-1:0]   g,
  input  logic [SIZE-1:0]   h,
  input  logic [SIZE-1:0]   constant,
  input  logic              approx_en,
  output logic [SIZE+4:0]   sum,
  output logic              out_valid
);
  localparam int W = SIZE + 5;
  localparam logic [W-1:0] LOW_MASK = W'((1 << APPROX_BITS) - 1);
  logic [SIZE-1:0] ops [9];
  logic [W-1:0] ext [9];
  logic [W-1:0] row [9];
  logic [W-1:0] low_or, low;
  logic [W-1:0] s0, c0, s1, c1, s2, c2, t0, u0, t1, u1, v0, w0, fs, fc;
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
  endfunction
  assign ops = '{a, b, c, d, e, f, g, h, constant};
  for (genvar i = 0; i < 9; i++) begin : g_ext
    assign ext[i] = {{5{ops[i][SIZE-1]}}, ops[i]};
    assign row[i] = approx_en ? (ext[i] & ~LOW_MASK) : ext[i];
  end
  // Masked rows leave the low columns zero, so no carry leaves them and the OR bits can be merged after the CPA.
  always_comb begin
    low_or = '0;
    for (int i = 0; i < 9; i++) low_or = low_or | (ext[i] & LOW_MASK);
  end
  assign low = approx_en ? low_or : '0;
  assign {s0, c0} = csa(row[0], row[1], row[2]);
  assign {s1, c1} = csa(row[3], row[4], row[5]);
  assign {s2, c2} = csa(row[6], row[7], row[8]);
  assign {t0, u0} = csa(s0, c0, s1);
  assign {t1, u1} = csa(c1, s2, c2);
  assign {v0, w0} = csa(t0, u0, t1);
  assign {fs, fc} = csa(v0, w0, u1);
`ifdef CSA_EIGHT_PIPE_EN
  logic [W-1:0] fs_q, fc_q, low_q;
  logic v_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= '0;
      fc_q <= '0;
      low_q <= '0;
      v_q <= 1'b0;
      sum <= '0;
      out_valid <= 1'b0;
    end else begin
      v_q <= in_valid;
      out_valid <= v_q;
      if (in_valid) begin
        fs_q <= fs;
        fc_q <= fc;
        low_q <= low;
      end
      if (v_q) sum <= (fs_q + fc_q) | low_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) sum <= (fs + fc) | low;
    end
  end
`endif
endmodule

// File: tb/tb_csa_eight_adder.sv
// tb_csa_eight_adder: randomized and directed checks of csa_eight_adder against an arithmetic reference model.
module tb_csa_eight_adder;
  localparam int SIZE = 8;
  localparam int AB = 2;
  localparam int W = SIZE + 5;
`ifdef CSA_EIGHT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n, in_valid, approx_en, out_valid;
  logic [SIZE-1:0] a, b, c, d, e, f, g, h, constant;
  logic [W-1:0] sum;
  int n_vec = 0;
  int n_err = 0;
  logic hv [3];
  logic [W-1:0] hs [3];
  logic [W-1:0] model_sum;

  csa_eight_adder #(.SIZE(SIZE), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .constant(constant), .approx_en(approx_en), .sum(sum), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_sum(input logic ax);
    int v [9];
    int tot = 0, upper = 0, lowi = 0;
    v = '{int'($signed(a)), int'($signed(b)), int'($signed(c)), int'($signed(d)), int'($signed(e)),
          int'($signed(f)), int'($signed(g)), int'($signed(h)), int'($signed(constant))};
    for (int i = 0; i < 9; i++) begin
      tot += v[i];
      upper += v[i] >>> AB;
      lowi |= v[i] & ((1 << AB) - 1);
    end
    return ax ? W'((upper << AB) | lowi) : W'(tot);
  endfunction

  task automatic put(input int va, input int vb, input int vc, input int vd, input int ve,
                     input int vf, input int vg, input int vh, input int vk, input logic ax);
    a = SIZE'(va); b = SIZE'(vb); c = SIZE'(vc); d = SIZE'(vd); e = SIZE'(ve);
    f = SIZE'(vf); g = SIZE'(vg); h = SIZE'(vh); constant = SIZE'(vk); approx_en = ax;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      hs[i] = '0;
    end
    model_sum = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) clear_model();
    else begin
      for (int i = 2; i > 0; i--) begin
        hv[i] = hv[i-1];
        hs[i] = hs[i-1];
      end
      hv[0] = in_valid;
      hs[0] = ref_sum(approx_en);
    end
    #1;
    if (rst_n && hv[LAT-1]) model_sum = hs[LAT-1];
  endtask

  task automatic test_reset();
    put(127, 60, 45, 35, 100, 120, 127, 90, 3, 1'b0);
    in_valid = 1'b1;
    step();
    step();
    n_vec++;
    if (out_valid !== 1'b1 || sum !== model_sum) begin
      n_err++;
      $display("FAIL reset_pre: out_valid=%0b sum=%0d required out_valid=1 sum=%0d", out_valid, $signed(sum), $signed(model_sum));
    end
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    n_vec++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: out_valid=%0b sum=%0d required 0 0", out_valid, $signed(sum));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (sum !== '0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: out_valid=%0b sum=%0d required 0 0", out_valid, $signed(sum));
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      n_vec++;
      if (out_valid !== hv[LAT-1] || sum !== model_sum) begin
        n_err++;
        $display("FAIL reset_resume: out_valid=%0b sum=%0d required %0b %0d", out_valid, $signed(sum), hv[LAT-1], $signed(model_sum));
      end
    end
    in_valid = 1'b0;
    repeat (LAT) step();
  endtask

  task automatic test_exact_positive();
    put(127, 60, 45, 35, 100, 120, 127, 90, 3, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      step();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== (i == LAT - 1)) begin
        n_err++;
        $display("FAIL exact_pos_valid: cycle %0d out_valid=%0b required %0b", i + 1, out_valid, i == LAT - 1);
      end
    end
    n_vec++;
    if (sum !== W'(707)) begin
      n_err++;
      $display("FAIL exact_pos_sum: sum=%0d required 707", $signed(sum));
    end
    step();
  endtask

  task automatic test_exact_mixed();
    put(-1, 121, 1, 1, -128, -128, 5, 2, 3, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    n_vec++;
    if (out_valid !== 1'b1 || sum !== W'(-124)) begin
      n_err++;
      $display("FAIL exact_mixed: out_valid=%0b sum=%0d required 1 -124", out_valid, $signed(sum));
    end
    step();
  endtask

  task automatic test_extremes();
    logic [W-1:0] seen [$];
    int first_cyc = -1, last_cyc = -1;
    put(127, 127, 127, 127, 127, 127, 127, 127, 0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (i == 0) put(-128, -128, -128, -128, -128, -128, -128, -128, 8, 1'b0);
      else in_valid = 1'b0;
      n_vec++;
      if (out_valid !== hv[LAT-1] || sum !== model_sum) begin
        n_err++;
        $display("FAIL extremes_model: cycle %0d out_valid=%0b sum=%0d required %0b %0d", i, out_valid, $signed(sum), hv[LAT-1], $signed(model_sum));
      end
      if (out_valid) begin
        seen.push_back(sum);
        if (first_cyc < 0) first_cyc = i;
        last_cyc = i;
      end
    end
    n_vec++;
    if (seen.size() != 2 || seen[0] !== W'(1016) || seen[1] !== W'(-1016) || last_cyc != first_cyc + 1) begin
      n_err++;
      $display("FAIL extremes_b2b: %0d results (first %0d), cycles %0d..%0d, required 1016 then -1016 on consecutive cycles",
               seen.size(), seen.size() > 0 ? $signed(seen[0]) : 0, first_cyc, last_cyc);
    end
  endtask

  task automatic test_approx();
    for (int m = 1; m >= 0; m--) begin
      put(1, 1, 1, 1, 1, 1, 1, 1, 0, m[0]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (LAT - 1) step();
      n_vec++;
      if (sum !== (m == 1 ? W'(1) : W'(8))) begin
        n_err++;
        $display("FAIL approx_ones: approx_en=%0d sum=%0d required %0d", m, $signed(sum), m == 1 ? 1 : 8);
      end
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      put($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      step();
      n_vec++;
      if (out_valid !== hv[LAT-1] || sum !== model_sum) begin
        n_err++;
        $display("FAIL random: iter %0d out_valid=%0b sum=%0d required %0b %0d", i, out_valid, $signed(sum), hv[LAT-1], $signed(model_sum));
      end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) put(-128, -128, -128, -128, -128, -128, -128, -128, -128, 1'($urandom));
      else put($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
      step();
      if (i == 39) in_valid = 1'b0;
      n_vec++;
      if (out_valid !== hv[LAT-1] || sum !== model_sum) begin
        n_err++;
        $display("FAIL back_to_back: iter %0d out_valid=%0b sum=%0d required %0b %0d", i, out_valid, $signed(sum), hv[LAT-1], $signed(model_sum));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    clear_model();
    #12;
    n_vec++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: out_valid=%0b sum=%0d required 0 0", out_valid, $signed(sum));
    end
    rst_n = 1'b1;
    step();
    test_reset();
    test_exact_positive();
    test_exact_mixed();
    test_extremes();
    test_approx();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
